// File: rtl/accum_table_ctrl.sv
// Accumulator-table sequencer: per-column skewed read/write enables and addresses for one tile.
// Define ACCUM_TBL_CTRL_SKEW_EN to skew column c by c cycles; otherwise all columns run in lockstep.
module accum_table_ctrl #(
    parameter int SYS_ARR_COLS   = 16,
    parameter int NUM_ACCUM_ROWS = 1024,
    parameter int ADDR_W         = $clog2(NUM_ACCUM_ROWS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic [ADDR_W:0]                num_rows,
    input  logic                           accumulate,
    output logic [SYS_ARR_COLS-1:0]        rd_en,
    output logic [SYS_ARR_COLS-1:0]        wr_en,
    output logic [ADDR_W*SYS_ARR_COLS-1:0] rd_addr,
    output logic [ADDR_W*SYS_ARR_COLS-1:0] wr_addr,
    output logic                           busy,
    output logic                           done
);

`ifdef ACCUM_TBL_CTRL_SKEW_EN
    localparam bit SKEW_EN = 1'b1;
`else
    localparam bit SKEW_EN = 1'b0;
`endif

    localparam int MAX_SKEW = SKEW_EN ? SYS_ARR_COLS - 1 : 0;
    localparam int TW       = ADDR_W + $clog2(SYS_ARR_COLS) + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                     state, state_nxt;
    logic [TW-1:0]                  t, t_nxt, last_t;
    logic [ADDR_W-1:0]              base_q, base_nxt;
    logic [ADDR_W:0]                num_q, num_nxt;
    logic                           acc_q, acc_nxt;
    logic                           accept;
    logic [TW-1:0]                  skew, rel;
    logic [SYS_ARR_COLS-1:0]        win_q, win_nxt;
    logic [ADDR_W*SYS_ARR_COLS-1:0] waddr_q, waddr_nxt;

    // Outputs are registered from next-state values so t=0 is visible right after acceptance.
    always_comb begin
        accept    = (state == S_IDLE) && start;
        base_nxt  = accept ? base_addr : base_q;
        num_nxt   = accept ? num_rows : num_q;
        acc_nxt   = accept ? accumulate : acc_q;
        last_t    = TW'(num_q) + TW'(MAX_SKEW);
        state_nxt = state;
        t_nxt     = t;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_rows == '0) ? S_DONE : S_RUN;
                    t_nxt     = '0;
                end
            end
            S_RUN: begin
                t_nxt = t + TW'(1);
                if (t == last_t) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        win_nxt   = '0;
        waddr_nxt = '0;
        skew      = '0;
        rel       = '0;
        for (int c = 0; c < SYS_ARR_COLS; c++) begin
            skew       = SKEW_EN ? TW'(c) : '0;
            rel        = t_nxt - skew;
            win_nxt[c] = (state_nxt == S_RUN) && (t_nxt >= skew) && (rel < TW'(num_nxt));
            waddr_nxt[c*ADDR_W +: ADDR_W] = win_nxt[c] ? base_nxt + rel[ADDR_W-1:0] : '0;
        end
    end

    // Write side replays the previous cycle's read window, giving the one-cycle RMW lag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            t       <= '0;
            base_q  <= '0;
            num_q   <= '0;
            acc_q   <= 1'b0;
            win_q   <= '0;
            waddr_q <= '0;
            rd_en   <= '0;
            wr_en   <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            t       <= t_nxt;
            base_q  <= base_nxt;
            num_q   <= num_nxt;
            acc_q   <= acc_nxt;
            win_q   <= win_nxt;
            waddr_q <= waddr_nxt;
            rd_en   <= acc_nxt ? win_nxt : '0;
            rd_addr <= acc_nxt ? waddr_nxt : '0;
            wr_en   <= win_q;
            wr_addr <= waddr_q;
            busy    <= (state_nxt == S_RUN);
            done    <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_accum_table_ctrl.sv
// Scoreboard bench for accum_table_ctrl (4 columns, 16 rows); the tile model is computed from
// window arithmetic and pushed as per-cycle expected output snapshots.
module tb_accum_table_ctrl;

    localparam int COLS = 4;
    localparam int ROWS = 16;
    localparam int AW   = 4;
    localparam int OW   = 2 * COLS + 2 * AW * COLS + 2;

`ifdef ACCUM_TBL_CTRL_SKEW_EN
    localparam bit SKEW_EN = 1'b1;
`else
    localparam bit SKEW_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [AW-1:0]      base_addr = '0;
    logic [AW:0]        num_rows = '0;
    logic               accumulate = 1'b0;
    logic [COLS-1:0]    rd_en, wr_en;
    logic [AW*COLS-1:0] rd_addr, wr_addr;
    logic               busy, done;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] obs;
    int checks = 0;
    int passed = 0;

    accum_table_ctrl #(.SYS_ARR_COLS(COLS), .NUM_ACCUM_ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .accumulate(accumulate), .rd_en(rd_en), .wr_en(wr_en),
        .rd_addr(rd_addr), .wr_addr(wr_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign obs = {rd_en, wr_en, rd_addr, wr_addr, busy, done};

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got rd_en=%h wr_en=%h rd_addr=%h wr_addr=%h busy=%b done=%b, expected rd_en=%h wr_en=%h rd_addr=%h wr_addr=%h busy=%b done=%b",
                      name, act[OW-1 -: COLS], act[OW-COLS-1 -: COLS], act[2*AW*COLS+1 -: AW*COLS],
                      act[AW*COLS+1 -: AW*COLS], act[1], act[0], exp[OW-1 -: COLS],
                      exp[OW-COLS-1 -: COLS], exp[2*AW*COLS+1 -: AW*COLS], exp[AW*COLS+1 -: AW*COLS],
                      exp[1], exp[0]);
    endtask

    // Reference model: tile runs cycles 1..L, done in cycle L+1; column c reads row (t - skew).
    task automatic push_tile(input int base, input int num, input bit acc, output int len);
        int s_max;
        s_max = SKEW_EN ? COLS - 1 : 0;
        len = (num == 0) ? 0 : num + s_max + 1;
        for (int n = 1; n <= len; n++) begin
            logic [COLS-1:0]    e_rd, e_wr;
            logic [AW*COLS-1:0] e_ra, e_wa;
            int t;
            t = n - 1;
            e_rd = '0; e_wr = '0; e_ra = '0; e_wa = '0;
            for (int c = 0; c < COLS; c++) begin
                int s, r, w;
                s = SKEW_EN ? c : 0;
                r = t - s;
                w = t - 1 - s;
                if (acc && r >= 0 && r < num) begin
                    e_rd[c] = 1'b1;
                    e_ra[c*AW +: AW] = AW'((base + r) % ROWS);
                end
                if (w >= 0 && w < num) begin
                    e_wr[c] = 1'b1;
                    e_wa[c*AW +: AW] = AW'((base + w) % ROWS);
                end
            end
            exp_q.push_back({e_rd, e_wr, e_ra, e_wa, 1'b1, 1'b0});
        end
        exp_q.push_back({{(OW-1){1'b0}}, 1'b1});
    endtask

    task automatic run_tile(input int base, input int num, input bit acc, input bit ignore_mid);
        int len;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = AW'(base);
        num_rows = (AW+1)'(num);
        accumulate = acc;
        push_tile(base, num, acc, len);
        @(posedge clk);
        // Scramble command inputs after acceptance; the tile must use the captured values.
        for (int k = 1; k <= len + 1; k++) begin
            #1;
            start = ignore_mid && (k == 2);
            base_addr = AW'($urandom_range(0, ROWS - 1));
            num_rows = (AW+1)'($urandom_range(0, ROWS));
            accumulate = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        #1;
        start = 1'b0;
    endtask

    // Monitor: any nonzero output is a presented response and must match the queue head.
    always @(negedge clk) begin
        if (reset && obs != '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got %h, expected no activity", obs);
            end else begin
                check("tile_cycle", obs, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2;
        check("reset_values", obs, '0);
        #20;
        reset = 1'b1;
        repeat (2) @(posedge clk);

        run_tile(2, 3, 1'b1, 1'b0);
        run_tile(14, 4, 1'b1, 1'b0);
        run_tile(0, 2, 1'b0, 1'b0);
        run_tile(5, 0, 1'b1, 1'b0);
        run_tile(9, 5, 1'b1, 1'b1);
        run_tile(0, 16, 1'b1, 1'b0);

        // Abandon a num_rows=8 tile during its third cycle.
        begin
            int len;
            @(posedge clk);
            #1;
            start = 1'b1; base_addr = 4'd3; num_rows = 5'd8; accumulate = 1'b1;
            push_tile(3, 8, 1'b1, len);
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b0;
            exp_q.delete();
            #1;
            check("reset_mid_tile", obs, '0);
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b1;
            repeat (20) @(posedge clk);
        end
        run_tile(7, 3, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_tile($urandom_range(0, ROWS - 1), $urandom_range(0, ROWS),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (30) @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d responses still pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        checks++;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
